// File: rtl/tcs3200_scan_ctrl_if.sv
// Sensor-side and result-side signals of the TCS3200 scan controller.
// slave: the controller itself; master: whoever drives start/sensor and consumes frames.
interface tcs3200_scan_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             continuous;
  logic [1:0]       freq_scale;
  logic             sensor_out;
  logic [1:0]       s0_s1;
  logic [1:0]       s2_s3;
  logic [CNT_W-1:0] red_cnt;
  logic [CNT_W-1:0] blue_cnt;
  logic [CNT_W-1:0] clear_cnt;
  logic [CNT_W-1:0] green_cnt;
  logic             busy;
  logic             frame_valid;
  logic             overflow;

  modport slave (
    input  start, continuous, freq_scale, sensor_out,
    output s0_s1, s2_s3, red_cnt, blue_cnt, clear_cnt, green_cnt,
           busy, frame_valid, overflow
  );

  modport master (
    output start, continuous, freq_scale, sensor_out,
    input  s0_s1, s2_s3, red_cnt, blue_cnt, clear_cnt, green_cnt,
           busy, frame_valid, overflow
  );
endinterface

// File: rtl/tcs3200_scan_ctrl.sv
// TCS3200 scan sequencer: steps the filter select red->blue->clear->green,
// settles after each change, counts synchronised sensor rising edges over a
// gate window, and publishes the four counts as one coherent frame.
module tcs3200_scan_ctrl #(
  parameter int SETTLE_CYCLES = 100,
  parameter int WINDOW_CYCLES = 1000,
  parameter int CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  tcs3200_scan_ctrl_if.slave bus
);
  localparam int TMAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0]    SET_LAST = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0]    WIN_LAST = TW'(WINDOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_e;

  state_e                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [1:0]              f_q, f_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_nx;
  logic                    sticky_q, sticky_d;
  logic                    meta_q, sync_q, sync_qq;
  logic [3:0][CNT_W-1:0]   shadow_q;
  logic [1:0]              s0s1_q;
  logic [CNT_W-1:0]        red_q, blue_q, clear_q, green_q;
  logic                    fv_q, ovf_q;
  logic                    edge_det, sat_hit, cap, win_end, publish;

  // Rising edge of the synchronised sensor; an edge arriving at the counter
  // maximum is dropped and marks the frame as saturated (count was clamped).
  assign edge_det = sync_q & ~sync_qq;
  assign sat_hit  = (state_q == COUNT) && edge_det && (cnt_q == CNT_MAX);
  assign cnt_nx   = (edge_det && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
  assign win_end  = (state_q == COUNT) && (timer_q == WIN_LAST);
  assign publish  = win_end && (f_q == 2'd3);

  // Two-process FSM: next state, phase timer, filter index and edge counter.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    f_d      = f_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    cap      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETTLE;
          timer_d = '0;
          f_d     = 2'd0;
          cap     = 1'b1;
        end
      end
      SETTLE: begin
        cnt_d = '0;
        if (timer_q == SET_LAST) begin
          state_d = COUNT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      COUNT: begin
        cnt_d = cnt_nx;
        if (sat_hit) sticky_d = 1'b1;
        if (win_end) begin
          cnt_d   = '0;
          timer_d = '0;
          if (f_q == 2'd3) begin
            state_d = DONE;
          end else begin
            f_d     = f_q + 2'd1;
            state_d = SETTLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: begin
        sticky_d = 1'b0;
        timer_d  = '0;
        f_d      = 2'd0;
        if (bus.continuous || bus.start) begin
          state_d = SETTLE;
          cap     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, sequencing registers and the sensor synchroniser.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      f_q      <= 2'd0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      sync_qq  <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      f_q      <= f_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      meta_q   <= bus.sensor_out;
      sync_q   <= meta_q;
      sync_qq  <= sync_q;
    end
  end

  // Per-channel shadows and the published frame; green goes straight from the
  // counter because its shadow would only be written on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_q <= '0;
      s0s1_q   <= 2'b00;
      red_q    <= '0;
      blue_q   <= '0;
      clear_q  <= '0;
      green_q  <= '0;
      fv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      fv_q <= publish;
      if (cap)     s0s1_q       <= bus.freq_scale;
      if (win_end) shadow_q[f_q] <= cnt_nx;
      if (publish) begin
        red_q   <= shadow_q[0];
        blue_q  <= shadow_q[1];
        clear_q <= shadow_q[2];
        green_q <= cnt_nx;
        ovf_q   <= sticky_q | sat_hit;
      end
    end
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.s2_s3       = (state_q != IDLE) ? f_q : 2'b00;
  assign bus.s0_s1       = s0s1_q;
  assign bus.red_cnt     = red_q;
  assign bus.blue_cnt    = blue_q;
  assign bus.clear_cnt   = clear_q;
  assign bus.green_cnt   = green_q;
  assign bus.frame_valid = fv_q;
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_tcs3200_scan_ctrl.sv
// Randomised bench for tcs3200_scan_ctrl: a 16-bit and a 3-bit instance share
// stimulus; a frame-level model predicts busy/filter/frame timing and counts
// from the logged pin samples.
module tb_tcs3200_scan_ctrl;
  localparam int S  = 4;
  localparam int W  = 20;
  localparam int PH = S + W;
  localparam int FR = 4 * PH;
  localparam int NW = 16;
  localparam int NN = 3;
  localparam int WMAX = (1 << NW) - 1;
  localparam int NMAX = (1 << NN) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0, cont = 1'b0, sensor = 1'b0;
  logic [1:0] fs = 2'b00;

  always #5 clk = ~clk;

  tcs3200_scan_ctrl_if #(.CNT_W(NW)) bw ();
  tcs3200_scan_ctrl_if #(.CNT_W(NN)) bn ();

  assign bw.start = start;  assign bw.continuous = cont;
  assign bw.freq_scale = fs; assign bw.sensor_out = sensor;
  assign bn.start = start;  assign bn.continuous = cont;
  assign bn.freq_scale = fs; assign bn.sensor_out = sensor;

  tcs3200_scan_ctrl #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(NW)) u_dut_w (
    .clk(clk), .rst(rst_n), .bus(bw.slave));
  tcs3200_scan_ctrl #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .CNT_W(NN)) u_dut_n (
    .clk(clk), .rst(rst_n), .bus(bn.slave));

  int   n_chk = 0, n_pass = 0, cyc = 0;
  bit   p [0:19999];
  bit   m_busy = 1'b0;
  int   m_e0 = 0;
  logic [1:0] m_s0s1 = 2'b00;
  int   pub_w [4] = '{0, 0, 0, 0};
  int   pub_n [4] = '{0, 0, 0, 0};
  bit   ovf_w = 1'b0, ovf_n = 1'b0;
  int   per = 2, run = 0, ph = 0;
  bit   rnd_mode = 1'b0, fast = 1'b0, no_cont = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  // Rising edges seen by the gate of channel f: the counter sees the pin two
  // samples late, and the gate spans the last W clocks of each filter slot.
  function automatic int raw_cnt(input int e0, input int f);
    int c = 0;
    for (int m = e0 + f * PH + S + 1; m <= e0 + f * PH + PH; m++)
      if (p[m-2] && !p[m-3]) c++;
    return c;
  endfunction

  task automatic model_edge();
    int r;
    if (!m_busy) begin
      if (start) begin m_busy = 1'b1; m_e0 = cyc; m_s0s1 = fs; end
    end else if (cyc == m_e0 + FR) begin
      ovf_w = 1'b0; ovf_n = 1'b0;
      for (int f = 0; f < 4; f++) begin
        r = raw_cnt(m_e0, f);
        pub_w[f] = (r > WMAX) ? WMAX : r;
        pub_n[f] = (r > NMAX) ? NMAX : r;
        if (r > WMAX) ovf_w = 1'b1;
        if (r > NMAX) ovf_n = 1'b1;
      end
    end else if (cyc == m_e0 + FR + 1) begin
      if (cont || start) begin m_e0 = cyc; m_s0s1 = fs; end
      else m_busy = 1'b0;
    end
  endtask

  task automatic check_outputs();
    int d, fe;
    d  = cyc - m_e0;
    fe = (d / PH > 3) ? 3 : d / PH;
    chk("busy",    32'(bw.busy), 32'(m_busy));
    chk("busy_n",  32'(bn.busy), 32'(m_busy));
    chk("s2_s3",   32'(bw.s2_s3), m_busy ? 32'(fe) : 32'd0);
    chk("s0_s1",   32'(bw.s0_s1), 32'(m_s0s1));
    chk("fvalid",  32'(bw.frame_valid), 32'(m_busy && d == FR));
    chk("fvalid_n", 32'(bn.frame_valid), 32'(m_busy && d == FR));
    chk("red",     32'(bw.red_cnt),   32'(pub_w[0]));
    chk("blue",    32'(bw.blue_cnt),  32'(pub_w[1]));
    chk("clear",   32'(bw.clear_cnt), 32'(pub_w[2]));
    chk("green",   32'(bw.green_cnt), 32'(pub_w[3]));
    chk("ovf",     32'(bw.overflow),  32'(ovf_w));
    chk("red_n",   32'(bn.red_cnt),   32'(pub_n[0]));
    chk("blue_n",  32'(bn.blue_cnt),  32'(pub_n[1]));
    chk("clear_n", 32'(bn.clear_cnt), 32'(pub_n[2]));
    chk("green_n", 32'(bn.green_cnt), 32'(pub_n[3]));
    chk("ovf_n",   32'(bn.overflow),  32'(ovf_n));
  endtask

  task automatic zero_chk();
    chk("rst_busy",  32'(bw.busy), 32'd0);
    chk("rst_s2_s3", 32'(bw.s2_s3), 32'd0);
    chk("rst_s0_s1", 32'(bw.s0_s1), 32'd0);
    chk("rst_fv",    32'(bw.frame_valid), 32'd0);
    chk("rst_ovf",   32'(bw.overflow), 32'd0);
    chk("rst_red",   32'(bw.red_cnt), 32'd0);
    chk("rst_blue",  32'(bw.blue_cnt), 32'd0);
    chk("rst_clear", 32'(bw.clear_cnt), 32'd0);
    chk("rst_green", 32'(bw.green_cnt), 32'd0);
    chk("rst_busy_n", 32'(bn.busy), 32'd0);
    chk("rst_cnt_n", 32'({bn.red_cnt, bn.blue_cnt, bn.clear_cnt, bn.green_cnt}), 32'd0);
    chk("rst_ovf_n", 32'(bn.overflow), 32'd0);
  endtask

  task automatic drive_inputs(input int start_pct);
    if (run == 0) begin
      per      = fast ? 2 : int'($urandom_range(2, 12));
      run      = int'($urandom_range(10, 60));
      rnd_mode = !fast && ($urandom_range(0, 3) == 0);
      ph       = 0;
    end
    run--;
    sensor = rnd_mode ? 1'($urandom_range(0, 1)) : (ph < per / 2);
    ph     = (ph + 1) % per;
    start  = ($urandom_range(0, 99) < start_pct);
    if (no_cont) cont = 1'b0;
    else if ($urandom_range(0, 49) == 0) cont = ~cont;
    if ($urandom_range(0, 9) == 0) fs = 2'($urandom_range(0, 3));
  endtask

  task automatic step(input int start_pct);
    @(posedge clk);
    cyc++;
    p[cyc] = rst_n ? sensor : 1'b0;
    if (rst_n) model_edge();
    #1;
    if (rst_n) check_outputs();
    @(negedge clk);
    drive_inputs(start_pct);
  endtask

  // Reset in the middle of the blue gate with the sensor still toggling.
  task automatic mid_reset();
    int guard = 0;
    while (m_busy && guard < 400) begin step(0); guard++; end
    guard = 0;
    while (!m_busy && guard < 200) begin step(100); guard++; end
    repeat (38) step(0);
    #2;
    rst_n = 1'b0;
    p[cyc] = 1'b0; p[cyc-1] = 1'b0; p[cyc-2] = 1'b0;
    #1;
    zero_chk();
    m_busy = 1'b0; m_s0s1 = 2'b00; ovf_w = 1'b0; ovf_n = 1'b0;
    for (int f = 0; f < 4; f++) begin pub_w[f] = 0; pub_n[f] = 0; end
    repeat (3) step(0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 zero_chk();
    repeat (3) step(0);
    rst_n = 1'b1;
    repeat (2500) step(8);
    no_cont = 1'b1;
    mid_reset();
    no_cont = 1'b0;
    repeat (2500) step(30);
    fast = 1'b1; run = 0;
    repeat (500) step(100);
    fast = 1'b0; run = 0;
    repeat (500) step(100);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
